// File: rtl/ovl_fire_pkg.sv
// Shared types for the OVL fire scheduler: scheduler FSM states and ID-width helper.
package ovl_fire_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Width of a checker index; a single checker still needs one bit.
  function automatic int ovl_id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after i_last, wrapping.
module ovl_rr_arbiter
  import ovl_fire_pkg::*;
#(
  parameter int N   = 8,
  parameter int IDW = ovl_id_width(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic [IDW-1:0] o_gnt,
  output logic           o_any
);

  // Walk the search order backwards so the nearest request overwrites the rest.
  always_comb begin
    int w_idx;
    w_idx = 0;
    o_gnt = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = (int'(i_last) + k) % N;
      if (i_req[w_idx]) o_gnt = IDW'(w_idx);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/ovl_fire_scheduler.sv
// Collects per-checker fire pulses and offers them one at a time, round-robin,
// on a valid/ready report channel with overflow flag and accepted-report count.
module ovl_fire_scheduler
  import ovl_fire_pkg::*;
#(
  parameter int NUM_CHECKERS = 8,
  parameter int CNT_WIDTH    = 8,
  localparam int IDW         = ovl_id_width(NUM_CHECKERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHECKERS-1:0] fire,
  input  logic [NUM_CHECKERS-1:0] enable_mask,
  input  logic                    clear,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [IDW-1:0]          report_id,
  output logic                    report_overflow,
  output logic [CNT_WIDTH-1:0]    report_count
);

  state_e                  r_state, w_next;
  logic [NUM_CHECKERS-1:0] r_pend, r_ovf;
  logic [IDW-1:0]          r_last, r_id;
  logic                    r_rovf;
  logic [CNT_WIDTH-1:0]    r_cnt;

  logic [NUM_CHECKERS-1:0] w_cap;
  logic [IDW-1:0]          w_gidx;
  logic                    w_any, w_grant, w_hs;

  assign w_cap = fire & enable_mask;

  ovl_rr_arbiter #(.N(NUM_CHECKERS), .IDW(IDW)) u_arb (
    .i_req  (r_pend),
    .i_last (r_last),
    .o_gnt  (w_gidx),
    .o_any  (w_any)
  );

  // A clear flushes pending state, so it also suppresses a grant in the same cycle.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_hs    = 1'b0;
    case (r_state)
      IDLE: if (w_any && !clear) begin
        w_grant = 1'b1;
        w_next  = OFFER;
      end
      OFFER: if (report_ready) begin
        w_hs   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else if (clear) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      for (int i = 0; i < NUM_CHECKERS; i++) begin
        // A fire on the winner during its grant is a fresh event, not an overflow.
        if (w_grant && (i == int'(w_gidx))) begin
          r_pend[i] <= w_cap[i];
          r_ovf[i]  <= 1'b0;
        end else if (w_cap[i]) begin
          r_pend[i] <= 1'b1;
          r_ovf[i]  <= r_ovf[i] | r_pend[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= IDW'(NUM_CHECKERS - 1);
      r_id   <= '0;
      r_rovf <= 1'b0;
    end else if (w_grant) begin
      r_last <= w_gidx;
      r_id   <= w_gidx;
      r_rovf <= r_ovf[w_gidx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_cnt <= '0;
    else if (clear)                r_cnt <= '0;
    else if (w_hs && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign report_valid    = (r_state == OFFER);
  assign report_id       = r_id;
  assign report_overflow = r_rovf;
  assign report_count    = r_cnt;

endmodule

// File: doc/ovl_fire_scheduler.md
OVL_FIRE_SCHEDULER -- requirements
Module: ovl_fire_scheduler

Interface
REQ-001 Parameter NUM_CHECKERS, default 8, SHALL set the number of checker fire inputs (legal range 2..32).
REQ-002 Parameter CNT_WIDTH, default 8, SHALL set the width of the accepted-report counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 fire  input  NUM_CHECKERS  SHALL carry one-cycle fire pulses, one bit per checker.
REQ-006 enable_mask  input  NUM_CHECKERS  SHALL gate fire capture per checker (1 = enabled).
REQ-007 clear  input  1  SHALL be a synchronous pulse that flushes all pending, overflow and count state.
REQ-008 report_valid  output  1  SHALL flag a report offered on the output channel.
REQ-009 report_ready  input  1  SHALL be the consumer's acceptance of a report.
REQ-010 report_id  output  $clog2(NUM_CHECKERS)  SHALL carry the index of the reported checker.
REQ-011 report_overflow  output  1  SHALL flag that the reported checker fired again while already pending.
REQ-012 report_count  output  CNT_WIDTH  SHALL carry the number of accepted reports.

Function
REQ-013 Capture: fire[i] & enable_mask[i] at edge t SHALL set pending[i] at edge t.
REQ-014 Capture with pending[i] already set and not being granted that cycle SHALL set overflow[i]; pending stays 1.
REQ-015 Masked fires SHALL be ignored; clearing a mask bit SHALL NOT clear an existing pending[i].
REQ-016 FSM states SHALL be IDLE and OFFER; the reset state is IDLE.
REQ-017 IDLE with any pending bit SHALL grant one index round-robin, searching upward from last_grant+1 with wrap from NUM_CHECKERS-1 to 0, and go to OFFER.
REQ-018 On grant, report_id and report_overflow SHALL be loaded from the winner, pending/overflow of the winner cleared, and last_grant updated.
REQ-019 A fire on the winning index in the grant cycle SHALL re-set pending with overflow 0 (a new event, not lost).
REQ-020 OFFER SHALL hold report_valid=1 and stable report_id/report_overflow until report_valid & report_ready.
REQ-021 Handshake cycle SHALL increment report_count (saturating at all-ones) and return to IDLE; minimum one IDLE cycle between reports.
REQ-022 Latency: fire at edge t SHALL, with idle scheduler and no competitors, give report_valid=1 after edge t+1.
REQ-023 report_ready while report_valid=0 SHALL have no effect.
REQ-024 clear SHALL zero pending, overflow and report_count; it SHALL NOT abort an OFFER in progress; clear and handshake in the same cycle leave report_count 0.
REQ-025 clear and fire in the same cycle: clear SHALL win (event discarded).

Reset
REQ-026 Reset SHALL force IDLE, report_valid=0, report_id=0, report_overflow=0, report_count=0, pending=0, overflow=0, last_grant=NUM_CHECKERS-1 (so index 0 wins first).
REQ-027 Reset asserted during OFFER SHALL drop report_valid immediately and discard the offered report.

Structure
REQ-028 Package ovl_fire_pkg SHALL hold the FSM state enum and the ID-width constant function.
REQ-029 Round-robin selection SHALL be a sub-module ovl_rr_arbiter (request vector, last_grant in; grant index, any-grant out; combinational).

Verification
REQ-030 fire=8'h01 for 1 cycle, ready=1 -> report_id=0, overflow=0, valid after edge t+1, report_count=1.
REQ-031 fire=8'hFF one cycle, ready=1 -> reports ids 0,1,...,7 in order, report_count=8.
REQ-032 fire[3] twice while OFFER of id 0 stalls (ready=0) -> later report id 3 with report_overflow=1, exactly one id-3 report.
REQ-033 fire[2] with enable_mask[2]=0 -> no report; report_count unchanged.
REQ-034 CNT_WIDTH=2, 5 accepted reports -> report_count saturates at 3; clear pulse -> 0, offered report still completes.
REQ-035 reset asserted mid-OFFER -> report_valid=0 in same cycle, all state at REQ-026 values.
